// File: rtl/sdram_pkg.sv
// Shared command encoding, error bit indices and mode-register field positions
// for the SDR SDRAM device responder.
package sdram_pkg;

  // {nRAS,nCAS,nWE} with nCS folded in by decode_cmd
  typedef enum logic [3:0] {
    CMD_LDM  = 4'b0000,
    CMD_AREF = 4'b0001,
    CMD_PRE  = 4'b0010,
    CMD_ACT  = 4'b0011,
    CMD_WR   = 4'b0100,
    CMD_RD   = 4'b0101,
    CMD_BST  = 4'b0110,
    CMD_NOP  = 4'b0111
  } cmd_e;

  localparam int ERR_ACT_OPEN    = 0;
  localparam int ERR_BANK_CLOSED = 1;
  localparam int ERR_REF_OPEN    = 2;
  localparam int ERR_MODE        = 3;
  localparam int ERR_NOINIT      = 4;
  localparam int ERR_BUS         = 5;
  localparam int ERR_W           = 6;

  localparam int MR_BL_LSB = 0;
  localparam int MR_BL_MSB = 2;
  localparam int MR_BT     = 3;
  localparam int MR_CL_LSB = 4;
  localparam int MR_CL_MSB = 6;
  localparam int MR_WB     = 9;

  localparam int CAS_LAT_DEF = 2;

  typedef struct packed {
    logic [1:0]      msk;
    logic [1:0][7:0] dat;
  } rd_stage_t;

  function automatic cmd_e decode_cmd(input logic ncs, input logic nras,
                                      input logic ncas, input logic nwe);
    if (ncs) return CMD_NOP;
    return cmd_e'({1'b0, nras, ncas, nwe});
  endfunction

  // Only burst length 1, sequential burst type and the supported CL load cleanly
  function automatic logic mode_legal(input logic [11:0] a, input int cl);
    return (a[MR_BL_MSB:MR_BL_LSB] == 3'd0) && !a[MR_BT] &&
           (a[MR_CL_MSB:MR_CL_LSB] == 3'(cl));
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Byte-laned storage for the SDRAM responder: per-byte write enables and a
// registered, enable-gated read port.
module sdram_resp_mem #(
  parameter int AW    = 12,
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic [LANES-1:0]      we,
  input  logic [AW-1:0]         addr,
  input  logic [LANES-1:0][7:0] wdata,
  input  logic                  re,
  output logic [LANES-1:0][7:0] rdata
);

  for (genvar b = 0; b < LANES; b++) begin : g_lane
    logic [7:0] ram [2**AW];
    logic [7:0] rd_q;

    // Read holds when re is low so a suspended pipeline keeps its word
    always_ff @(posedge clk) begin
      if (we[b]) ram[addr] <= wdata[b];
      if (re)    rd_q      <= ram[addr];
    end

    assign rdata[b] = rd_q;
  end

endmodule

// File: rtl/sdram_resp_x16.sv
// x16 SDR SDRAM target: decodes the command bus, tracks bank/mode state,
// stores data and returns reads at CAS latency 2 with sticky violation flags.
module sdram_resp_x16
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 8,
  parameter int CAS_LAT  = CAS_LAT_DEF
) (
  input  logic              C14M,
  input  logic              Reset,
  input  logic              CKE,
  input  logic              nCS,
  input  logic              nRAS,
  input  logic              nCAS,
  input  logic              nWE,
  input  logic [1:0]        BA,
  input  logic [11:0]       A,
  input  logic              DQML,
  input  logic              DQMH,
  input  logic [15:0]       DQ_in,
  output logic [15:0]       DQ_out,
  output logic              DQ_oe,
  output logic [ERR_W-1:0]  Err,
  output logic [11:0]       ModeReg,
  output logic [15:0]       RefCnt,
  output logic              Init
);

  localparam int AW     = 2 + ROW_BITS + COL_BITS;
  localparam int STAGES = 2;

  logic                     cke_q;
  logic                     exec;
  cmd_e                     cmd;
  logic [3:0]               bank_open;
  logic [3:0][ROW_BITS-1:0] bank_row;
  logic                     bank_hit;
  logic [AW-1:0]            addr;
  logic                     rd_go, wr_go;
  logic [1:0]               wr_be;
  logic [1:0][7:0]          mem_rdata;
  logic [STAGES:1]          vld_pipe;
  logic [1:0]               msk1;
  rd_stage_t                stg2;

  assign exec     = cke_q;
  assign cmd      = decode_cmd(nCS, nRAS, nCAS, nWE);
  assign bank_hit = bank_open[BA];
  assign addr     = {BA, bank_row[BA], A[COL_BITS-1:0]};
  assign rd_go    = exec && (cmd == CMD_RD) && bank_hit;
  assign wr_go    = exec && (cmd == CMD_WR) && bank_hit;
  assign wr_be    = {~DQMH, ~DQML} & {2{wr_go}};

  sdram_resp_mem #(.AW(AW), .LANES(2)) u_mem (
    .clk   (C14M),
    .we    (wr_be),
    .addr  (addr),
    .wdata (DQ_in),
    .re    (rd_go),
    .rdata (mem_rdata)
  );

  always_ff @(posedge C14M) begin
    if (Reset) begin
      cke_q     <= 1'b1;
      bank_open <= '0;
      bank_row  <= '0;
      vld_pipe  <= '0;
      msk1      <= '0;
      stg2      <= '0;
      DQ_out    <= '0;
      DQ_oe     <= 1'b0;
      Err       <= '0;
      ModeReg   <= '0;
      RefCnt    <= '0;
      Init      <= 1'b0;
    end else begin
      cke_q <= CKE;
      if (exec) begin
        // Stage 1 is the memory's own read register; stage 2 carries word + mask
        vld_pipe <= {vld_pipe[1], rd_go};
        msk1     <= {DQMH, DQML};
        stg2     <= '{msk: msk1, dat: mem_rdata};
        DQ_oe    <= vld_pipe[2] && !(&stg2.msk);
        if (vld_pipe[2])
          DQ_out <= stg2.dat & {{8{~stg2.msk[1]}}, {8{~stg2.msk[0]}}};

        unique case (cmd)
          CMD_ACT: begin
            if (bank_open[BA]) Err[ERR_ACT_OPEN] <= 1'b1;
            if (!Init)         Err[ERR_NOINIT]   <= 1'b1;
            bank_open[BA] <= 1'b1;
            bank_row[BA]  <= A[ROW_BITS-1:0];
          end
          CMD_RD, CMD_WR: begin
            if (!bank_hit) Err[ERR_BANK_CLOSED] <= 1'b1;
            if (!Init)     Err[ERR_NOINIT]      <= 1'b1;
            if (bank_hit && A[10]) bank_open[BA] <= 1'b0;
            if ((cmd == CMD_WR) && vld_pipe[2]) Err[ERR_BUS] <= 1'b1;
          end
          CMD_PRE: begin
            if (A[10]) bank_open     <= '0;
            else       bank_open[BA] <= 1'b0;
          end
          CMD_AREF: begin
            if (|bank_open)            Err[ERR_REF_OPEN] <= 1'b1;
            else if (RefCnt != '1)     RefCnt <= RefCnt + 16'd1;
          end
          CMD_LDM: begin
            if (|bank_open) Err[ERR_REF_OPEN] <= 1'b1;
            else begin
              ModeReg <= A;
              Init    <= 1'b1;
              if (!mode_legal(A, CAS_LAT)) Err[ERR_MODE] <= 1'b1;
            end
          end
          CMD_BST: Err[ERR_BUS] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_resp_x16.sv
// Directed bench for sdram_resp_x16: init, read/write, masks, CKE suspend,
// violations and reset during an outstanding read.
module tb_sdram_resp_x16;

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_RD   = 4'b0101;
  localparam logic [3:0] C_WR   = 4'b0100;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_LDM  = 4'b0000;

  logic        C14M = 1'b0;
  logic        Reset, CKE, nCS, nRAS, nCAS, nWE, DQML, DQMH;
  logic [1:0]  BA;
  logic [11:0] A;
  logic [15:0] DQ_in, DQ_out, RefCnt;
  logic        DQ_oe, Init;
  logic [5:0]  Err;
  logic [11:0] ModeReg;

  int n_chk = 0;
  int n_err = 0;

  always #5 C14M = ~C14M;

  sdram_resp_x16 dut (
    .C14M(C14M), .Reset(Reset), .CKE(CKE), .nCS(nCS), .nRAS(nRAS),
    .nCAS(nCAS), .nWE(nWE), .BA(BA), .A(A), .DQML(DQML), .DQMH(DQMH),
    .DQ_in(DQ_in), .DQ_out(DQ_out), .DQ_oe(DQ_oe), .Err(Err),
    .ModeReg(ModeReg), .RefCnt(RefCnt), .Init(Init)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one command, step one edge, sample 1ns after it
  task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [11:0] a,
                     input logic [1:0] dqm, input logic [15:0] d);
    {nCS, nRAS, nCAS, nWE} = c;
    BA = ba; A = a; {DQMH, DQML} = dqm; DQ_in = d;
    @(posedge C14M); #1;
  endtask

  task automatic nop();
    cmd(C_NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
  endtask

  task automatic do_init();
    cmd(C_PRE, 2'd0, 12'h400, 2'b00, 16'h0);
    cmd(C_LDM, 2'd0, 12'h220, 2'b00, 16'h0);
    for (int i = 0; i < 8; i++) cmd(C_AREF, 2'd0, 12'h000, 2'b00, 16'h0);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1; nop(); Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; CKE = 1'b1;
    {nCS, nRAS, nCAS, nWE} = C_NOP;
    BA = '0; A = '0; DQML = 1'b0; DQMH = 1'b0; DQ_in = '0;
    nop(); nop();
    Reset = 1'b0;
    chk("rst_oe",   32'(DQ_oe),   32'h0);
    chk("rst_out",  32'(DQ_out),  32'h0);
    chk("rst_err",  32'(Err),     32'h0);
    chk("rst_mode", 32'(ModeReg), 32'h0);
    chk("rst_ref",  32'(RefCnt),  32'h0);
    chk("rst_init", 32'(Init),    32'h0);

    // ACT before any LDM
    cmd(C_ACT, 2'd0, 12'h000, 2'b00, 16'h0);
    chk("act_noinit", 32'(Err), 32'h10);
    pulse_reset();
    chk("rst2_err", 32'(Err), 32'h0);

    do_init();
    chk("init_init", 32'(Init),    32'h1);
    chk("init_mode", 32'(ModeReg), 32'h220);
    chk("init_ref",  32'(RefCnt),  32'd8);
    chk("init_err",  32'(Err),     32'h0);

    // Write then read, CL=2
    cmd(C_ACT, 2'd1, 12'h003, 2'b00, 16'h0);
    cmd(C_WR,  2'd1, 12'h05A, 2'b00, 16'hBEEF);
    cmd(C_RD,  2'd1, 12'h05A, 2'b00, 16'h0);
    chk("rd_e0_oe", 32'(DQ_oe), 32'h0);
    nop(); chk("rd_e1_oe", 32'(DQ_oe), 32'h0);
    nop(); chk("rd_e2_oe", 32'(DQ_oe), 32'h1); chk("rd_e2_out", 32'(DQ_out), 32'hBEEF);
    nop(); chk("rd_e3_oe", 32'(DQ_oe), 32'h0); chk("rd_e3_hold", 32'(DQ_out), 32'hBEEF);

    // Byte masks
    cmd(C_WR, 2'd1, 12'h05A, 2'b10, 16'h1234);
    cmd(C_RD, 2'd1, 12'h05A, 2'b00, 16'h0); nop(); nop();
    chk("wmask_out", 32'(DQ_out), 32'hBE34);
    cmd(C_RD, 2'd1, 12'h05A, 2'b01, 16'h0); nop(); nop();
    chk("rmask_out", 32'(DQ_out), 32'hBE00);
    chk("rmask_oe",  32'(DQ_oe),  32'h1);

    // Back-to-back reads
    cmd(C_WR, 2'd1, 12'h05B, 2'b00, 16'h5555);
    cmd(C_RD, 2'd1, 12'h05A, 2'b00, 16'h0);
    cmd(C_RD, 2'd1, 12'h05B, 2'b00, 16'h0);
    nop(); chk("b2b_0", 32'(DQ_out), 32'hBE34); chk("b2b_0_oe", 32'(DQ_oe), 32'h1);
    nop(); chk("b2b_1", 32'(DQ_out), 32'h5555); chk("b2b_1_oe", 32'(DQ_oe), 32'h1);

    // CKE suspend: edges after RD with cke_q=0 do not advance the pipeline
    cmd(C_RD, 2'd1, 12'h05A, 2'b00, 16'h0);
    chk("cke_e0_oe", 32'(DQ_oe), 32'h0);
    CKE = 1'b0;
    nop();                                 // still executes (cke_q was 1)
    nop(); chk("cke_e2_oe", 32'(DQ_oe), 32'h0);
    cmd(C_PRE, 2'd0, 12'h400, 2'b00, 16'h0); // ignored
    chk("cke_e3_oe", 32'(DQ_oe), 32'h0);
    CKE = 1'b1;
    nop(); chk("cke_e4_oe", 32'(DQ_oe), 32'h0);
    nop(); chk("cke_e5_oe", 32'(DQ_oe), 32'h1); chk("cke_e5_out", 32'(DQ_out), 32'hBE34);

    // Auto-precharge; the ignored PRE above left bank 1 open
    cmd(C_RD, 2'd1, 12'h45A, 2'b00, 16'h0); nop(); nop();
    chk("ap_out", 32'(DQ_out), 32'hBE34);
    chk("ap_err", 32'(Err),    32'h00);
    cmd(C_RD, 2'd1, 12'h05A, 2'b00, 16'h0);
    chk("rd_closed_err", 32'(Err), 32'h02);
    nop(); nop();
    chk("rd_closed_oe", 32'(DQ_oe), 32'h0);

    // WR colliding with an emerging read
    cmd(C_ACT, 2'd1, 12'h003, 2'b00, 16'h0);
    cmd(C_RD,  2'd1, 12'h05A, 2'b00, 16'h0);
    nop();
    cmd(C_WR,  2'd1, 12'h05B, 2'b00, 16'h5555);
    chk("bus_err", 32'(Err),    32'h22);
    chk("bus_out", 32'(DQ_out), 32'hBE34);

    // ACT twice on bank 0
    cmd(C_ACT, 2'd0, 12'h000, 2'b00, 16'h0);
    chk("act1_err", 32'(Err), 32'h22);
    cmd(C_ACT, 2'd0, 12'h000, 2'b00, 16'h0);
    chk("act2_err", 32'(Err), 32'h23);

    // AREF with a bank open
    cmd(C_PRE,  2'd0, 12'h400, 2'b00, 16'h0);
    cmd(C_ACT,  2'd2, 12'h001, 2'b00, 16'h0);
    cmd(C_AREF, 2'd0, 12'h000, 2'b00, 16'h0);
    chk("aref_err", 32'(Err),    32'h27);
    chk("aref_cnt", 32'(RefCnt), 32'd8);

    // Illegal mode still loads
    cmd(C_PRE, 2'd0, 12'h400, 2'b00, 16'h0);
    cmd(C_LDM, 2'd0, 12'h231, 2'b00, 16'h0);
    chk("ldm_err",  32'(Err),     32'h2F);
    chk("ldm_mode", 32'(ModeReg), 32'h231);

    // Reset while a read is in flight
    cmd(C_ACT, 2'd1, 12'h003, 2'b00, 16'h0);
    cmd(C_WR,  2'd1, 12'h05A, 2'b00, 16'hBEEF);
    cmd(C_RD,  2'd1, 12'h05A, 2'b00, 16'h0);
    pulse_reset();
    chk("mid_rst_oe0", 32'(DQ_oe), 32'h0);
    nop(); chk("mid_rst_oe1", 32'(DQ_oe), 32'h0);
    nop(); chk("mid_rst_oe2", 32'(DQ_oe), 32'h0);
    chk("mid_rst_err",  32'(Err),  32'h0);
    chk("mid_rst_init", 32'(Init), 32'h0);
    do_init();
    cmd(C_ACT, 2'd1, 12'h003, 2'b00, 16'h0);
    cmd(C_RD,  2'd1, 12'h05A, 2'b00, 16'h0); nop(); nop();
    chk("keep_out", 32'(DQ_out), 32'hBEEF);
    chk("keep_oe",  32'(DQ_oe),  32'h1);
    chk("keep_err", 32'(Err),    32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
